// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial WIDTH-bit adder controller.
// One full-adder cell and a carry flip-flop process one bit per clock, LSB first.
// A start/busy/done handshake wraps the operation.
// Optional macro SERIAL_ADD_SUB_EN adds a `sub` input that selects a - b.
module serial_add_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] psum;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             bit_s;
  logic             bit_c;

  // Single full-adder cell: returns {carry_out, sum_bit}.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic c);
    full_add = {(x & y) | (c & (x ^ y)), x ^ y ^ c};
  endfunction

  // Adder cell fed by the operand LSBs and the stored carry.
  always_comb begin
    {bit_c, bit_s} = full_add(opa[0], opb[0], carry);
  end

  // Controller FSM with datapath shift registers and registered handshake outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      opa      <= '0;
      opb      <= '0;
      psum     <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        // DONE is the final cycle of an operation. Its exit edge samples start
        // exactly like IDLE, so a held request is accepted WIDTH+1 edges after
        // the previous accept. Start seen during RUN is dropped.
        IDLE, DONE: begin
          if (start) begin
            opa   <= a;
            cnt   <= '0;
            psum  <= '0;
`ifdef SERIAL_ADD_SUB_EN
            opb   <= sub ? ~b : b;
            carry <= sub ? 1'b1 : cin;
`else
            opb   <= b;
            carry <= cin;
`endif
            state <= RUN;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        RUN: begin
          opa   <= opa >> 1;
          opb   <= opb >> 1;
          psum  <= {bit_s, psum[WIDTH-1:1]};
          carry <= bit_c;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST_BIT) begin
            // Last bit: publish the result. carry still holds the carry into the MSB.
            sum      <= {bit_s, psum[WIDTH-1:1]};
            cout     <= bit_c;
            overflow <= carry ^ bit_c;
            done     <= 1'b1;
            state    <= DONE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: directed bench for serial_add_ctrl at WIDTH=8.
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         reset_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
`ifdef SERIAL_ADD_SUB_EN
  logic         sub;
`endif
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         overflow;

  int vectors;
  int miscompares;
  logic [W-1:0] last_sum;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .a        (a),
    .b        (b),
    .cin      (cin),
`ifdef SERIAL_ADD_SUB_EN
    .sub      (sub),
`endif
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .cout     (cout),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full operation from a single-cycle start pulse, checked at every milestone.
  task automatic op(input string tag, input logic [W-1:0] va, input logic [W-1:0] vb,
                    input logic vc, input logic [W-1:0] es, input logic ec, input logic eo);
    a = va; b = vb; cin = vc; start = 1'b1;
    tick();                                   // edge E
    start = 1'b0;
    chk({tag, " busy@E"}, busy, 1);
    repeat (W - 1) tick();                    // edge E+7
    chk({tag, " done@E+7"}, done, 0);
    chk({tag, " sum held@E+7"}, sum, last_sum);
    tick();                                   // edge E+8
    chk({tag, " sum"}, sum, es);
    chk({tag, " cout"}, cout, ec);
    chk({tag, " ovf"}, overflow, eo);
    chk({tag, " done@E+8"}, done, 1);
    chk({tag, " busy@E+8"}, busy, 1);
    tick();                                   // edge E+9
    chk({tag, " done@E+9"}, done, 0);
    chk({tag, " busy@E+9"}, busy, 0);
    last_sum = es;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    last_sum = '0;
    reset_n = 1'b0;
    start = 1'b0;
    a = '0; b = '0; cin = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
    sub = 1'b0;
`endif
    tick();
    tick();
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst sum", sum, 8'h00);
    chk("rst cout", cout, 0);
    chk("rst ovf", overflow, 0);

    // Release reset in the same cycle start is raised; first edge must accept.
    reset_n = 1'b1;
    op("add", 8'h3A, 8'h45, 1'b0, 8'h7F, 1'b0, 1'b0);
    op("wrap", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    op("ffcin", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
    op("ovpos", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    op("ovneg", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);

    // Held start: operands changed mid-run; second op accepted at E+9.
    a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
    tick();                                   // edge E
    a = 8'hAA; b = 8'h55;
    repeat (W) tick();                        // edge E+8
    chk("hold sum1", sum, 8'h46);
    chk("hold done1", done, 1);
    tick();                                   // edge E+9
    chk("hold busy@E+9", busy, 1);
    chk("hold done@E+9", done, 0);
    repeat (W - 1) tick();                    // edge E+16
    chk("hold sum kept@E+16", sum, 8'h46);
    chk("hold done@E+16", done, 0);
    start = 1'b0;
    tick();                                   // edge E+17
    chk("hold sum2", sum, 8'hFF);
    chk("hold cout2", cout, 0);
    chk("hold done2", done, 1);
    tick();
    chk("hold busy end", busy, 0);
    last_sum = 8'hFF;

    // Reset during the fourth RUN cycle.
    a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
    tick();                                   // edge E
    start = 1'b0;
    repeat (3) tick();
    chk("mid busy before rst", busy, 1);
    reset_n = 1'b0;
    #1;
    chk("mid rst busy", busy, 0);
    chk("mid rst sum", sum, 8'h00);
    chk("mid rst cout", cout, 0);
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < W + 2; i++) begin
      tick();
      chk("mid no done", done, 0);
    end
    last_sum = 8'h00;
    op("recover", 8'h01, 8'h02, 1'b1, 8'h04, 1'b0, 1'b0);

`ifdef SERIAL_ADD_SUB_EN
    sub = 1'b1;
    op("sub", 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0);
    sub = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
